// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus master.
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_e;

  typedef logic [2:0] lsu_state_e;
  localparam lsu_state_e ST_IDLE    = 3'd0;
  localparam lsu_state_e ST_RD_ADDR = 3'd1;
  localparam lsu_state_e ST_RD_DATA = 3'd2;
  localparam lsu_state_e ST_WR      = 3'd3;
  localparam lsu_state_e ST_RSP     = 3'd4;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);
endpackage

// File: rtl/lsu_align.sv
// Lane extract with sign/zero extension for loads, and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        zero_ext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    sh      = {lane, 3'b000};
    shifted = word >> sh;
    ld_data = shifted;
    mask    = 32'hFFFF_FFFF;
    case (size_e'(size))
      SZ_B: begin
        ld_data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
        mask    = 32'h0000_00FF;
      end
      SZ_H: begin
        ld_data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
        mask    = 32'h0000_FFFF;
      end
      default: ;
    endcase
    st_word = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end
endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator for the word-wide SRAM; sub-word stores use read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests return an error.
//
// state      | meaning
// IDLE       | req_ready=1, waiting for a request
// RD_ADDR    | read address on the bus, waiting for mem_ready
// RD_DATA    | capture read data (load result or RMW base word)
// WR         | single write pulse, held while mem_ready=0
// RSP        | response held until rsp_ready
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int RAM_SIZE = 5120,
  parameter int ADDR_W   = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  lsu_state_e        state;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane_in;
  logic              acc_err;
  logic              mis_err;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;

  always_comb begin
    word_idx = req_addr >> LANE_W;
    lane_in  = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    mis_err  = ((req_size == SZ_H) && req_addr[0]) ||
               ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    // Without the trap, misaligned requests snap to natural alignment.
    mis_err  = 1'b0;
    if (req_size == SZ_H) lane_in[0] = 1'b0;
    else if (req_size == SZ_W) lane_in = 2'b00;
`endif
    acc_err  = (word_idx >= ADDR_W'(RAM_SIZE)) || (req_size == 2'b11) || mis_err;
  end

  lsu_align u_align (
    .size     (size_q),
    .lane     (lane_q),
    .zero_ext (uns_q),
    .word     (mem_rdata),
    .wdata    (wdata_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            lane_q    <= lane_in;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= acc_err;
            if (acc_err) begin
              // Errors never touch the bus, so mem_addr keeps its old value.
              rsp_valid <= 1'b1;
              state     <= ST_RSP;
            end else begin
              mem_addr <= 32'(word_idx);
              if (req_we && (req_size == SZ_W)) begin
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
                state     <= ST_WR;
              end else begin
                state <= ST_RD_ADDR;
              end
            end
          end
        end
        ST_RD_ADDR: if (mem_ready) state <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (mem_ready) begin
            if (we_q) begin
              mem_we    <= 1'b1;
              mem_wdata <= st_word;
              state     <= ST_WR;
            end else begin
              rsp_rdata <= ld_data;
              rsp_valid <= 1'b1;
              state     <= ST_RSP;
            end
          end
        end
        ST_WR: begin
          if (mem_ready) begin
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master with a registered-read SRAM model.
module tb_lsu_bus_master;
  localparam int RAM_SIZE = 5120;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b1;

  always #5 HCLK = ~HCLK;

  lsu_bus_master #(.RAM_SIZE(RAM_SIZE), .ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  logic [31:0] sram [0:RAM_SIZE-1];
  logic        pl_en = 1'b0;
  logic [12:0] pl_a = '0;
  logic [31:0] pl_d = '0;
  int          wr_cnt = 0;
  logic [31:0] wr_a = '0;
  logic [31:0] wr_d = '0;

  always @(posedge HCLK) begin
    if (pl_en) sram[pl_a] <= pl_d;
    else if (HRESETn && mem_we && mem_ready && (mem_addr < RAM_SIZE)) sram[mem_addr[12:0]] <= mem_wdata;
    if (HRESETn && mem_we && mem_ready) begin
      wr_cnt <= wr_cnt + 1;
      wr_a   <= mem_addr;
      wr_d   <= mem_wdata;
    end
    mem_rdata <= (mem_addr < RAM_SIZE) ? sram[mem_addr[12:0]] : 32'h0;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wa;
    logic [31:0] exp_wd;
    int          exp_lat;
  } req_t;
  req_t tab [8];

  int total = 0;
  int bad = 0;

  task automatic preload(input logic [12:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge HCLK); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         output logic [31:0] o_rdata, output logic o_err, output int o_lat,
                         output logic o_to, output int o_unstable, output logic o_rdy_hs,
                         output logic o_rdy_after);
    logic p_rdy, p_we;
    logic [31:0] p_a, p_d;
    int k;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge HCLK); #1; k++; end
    @(posedge HCLK); #1;
    req_valid = 1'b0;
    if (stall > 0) mem_ready = 1'b0;
    o_lat = 1; o_to = 1'b1; o_unstable = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid) begin o_to = 1'b0; break; end
      p_rdy = mem_ready; p_we = mem_we; p_a = mem_addr; p_d = mem_wdata;
      @(posedge HCLK); #1;
      o_lat++;
      if (!p_rdy && p_we && (mem_we !== 1'b1 || mem_addr !== p_a || mem_wdata !== p_d)) o_unstable++;
      if (o_lat > stall) mem_ready = 1'b1;
    end
    o_rdata = rsp_rdata; o_err = rsp_err; o_rdy_hs = req_ready;
    rsp_ready = 1'b1;
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
    o_rdy_after = req_ready;
    mem_ready = 1'b1;
  endtask

  logic [31:0] r;
  logic er, to, rh, ra;
  int lat, un, w0;
  exp_t e;

  task automatic test_reset();
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata} !== {4'b1000, 96'h0}) begin
      bad++;
      $display("FAIL reset_values got rdy=%b v=%b err=%b we=%b rd=%h ma=%h wd=%h want rdy=1 rest 0",
               req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_load();
    tab[0] = '{0, 2'd0, 0, 32'h16, 0, 32'hFFFFFF99, 0, 0, 3};
    tab[1] = '{0, 2'd0, 1, 32'h16, 0, 32'h00000099, 0, 0, 3};
    tab[2] = '{0, 2'd0, 0, 32'h14, 0, 32'hFFFFFFBB, 0, 0, 3};
    tab[3] = '{0, 2'd1, 0, 32'h16, 0, 32'hFFFF8899, 0, 0, 3};
    tab[4] = '{0, 2'd1, 1, 32'h14, 0, 32'h0000AABB, 0, 0, 3};
    tab[5] = '{0, 2'd2, 0, 32'h14, 0, 32'h8899AABB, 0, 0, 3};
    tab[6] = '{0, 2'd0, 0, 32'h19, 0, 32'hFFFFFFFF, 0, 0, 3};
    tab[7] = '{0, 2'd1, 0, 32'h1A, 0, 32'h00007F80, 0, 0, 3};
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{tab[i].exp_rdata, 1'b0, tab[i].exp_lat});
      run_req(1'b0, tab[i].size, tab[i].uns, tab[i].addr, 32'h0, 0, r, er, lat, to, un, rh, ra);
      e = sb.pop_front();
      total++;
      if (to || r !== e.rdata || er !== e.err) begin
        bad++;
        $display("FAIL load%0d got rdata=%h err=%b timeout=%b want rdata=%h err=%b", i, r, er, to, e.rdata, e.err);
      end
      total++;
      if (lat !== e.lat) begin bad++; $display("FAIL load%0d_latency got=%0d want=%0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_store();
    tab[0] = '{1, 2'd1, 0, 32'h16, 32'h00001234, 0, 32'd5, 32'h1234AABB, 0};
    tab[1] = '{1, 2'd0, 0, 32'h11, 32'hFFFFFFA5, 0, 32'd4, 32'h1122A544, 0};
    tab[2] = '{1, 2'd2, 0, 32'h18, 32'hDEADBEEF, 0, 32'd6, 32'hDEADBEEF, 2};
    for (int i = 0; i < 3; i++) begin
      w0 = wr_cnt;
      sb.push_back('{32'h0, 1'b0, tab[i].exp_lat});
      run_req(1'b1, tab[i].size, 1'b0, tab[i].addr, tab[i].wdata, 0, r, er, lat, to, un, rh, ra);
      e = sb.pop_front();
      total++;
      if (to || r !== e.rdata || er !== e.err) begin
        bad++;
        $display("FAIL store%0d_rsp got rdata=%h err=%b timeout=%b want rdata=%h err=%b", i, r, er, to, e.rdata, e.err);
      end
      total++;
      if (wr_cnt - w0 !== 1 || wr_a !== tab[i].exp_wa || wr_d !== tab[i].exp_wd) begin
        bad++;
        $display("FAIL store%0d_write got n=%0d addr=%h data=%h want n=1 addr=%h data=%h",
                 i, wr_cnt - w0, wr_a, wr_d, tab[i].exp_wa, tab[i].exp_wd);
      end
      if (e.lat != 0) begin
        total++;
        if (lat !== e.lat) begin bad++; $display("FAIL store%0d_latency got=%0d want=%0d", i, lat, e.lat); end
      end
    end
    sb.push_back('{32'hDEADBEEF, 1'b0, 3});
    run_req(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, 0, r, er, lat, to, un, rh, ra);
    e = sb.pop_front();
    total++;
    if (to || r !== e.rdata || er !== e.err || lat !== e.lat) begin
      bad++;
      $display("FAIL store_readback got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d", r, er, lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_error();
    logic [31:0] ma;
    tab[0] = '{0, 2'd2, 0, RAM_SIZE * 4, 0, 0, 0, 0, 1};
    tab[1] = '{0, 2'd3, 0, 32'h14, 0, 0, 0, 0, 1};
    tab[2] = '{1, 2'd2, 0, RAM_SIZE * 4 + 8, 32'h55, 0, 0, 0, 1};
    tab[3] = '{1, 2'd0, 0, 32'hFFFF_FFF0, 32'h55, 0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt;
      ma = mem_addr;
      sb.push_back('{32'h0, 1'b1, 1});
      run_req(tab[i].we, tab[i].size, 1'b0, tab[i].addr, tab[i].wdata, 0, r, er, lat, to, un, rh, ra);
      e = sb.pop_front();
      total++;
      if (to || r !== e.rdata || er !== e.err || lat !== e.lat) begin
        bad++;
        $display("FAIL err%0d_rsp got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d", i, r, er, lat, e.rdata, e.err, e.lat);
      end
      total++;
      if (wr_cnt != w0 || mem_addr !== ma) begin
        bad++;
        $display("FAIL err%0d_no_access got writes=%0d mem_addr=%h want writes=0 mem_addr=%h", i, wr_cnt - w0, mem_addr, ma);
      end
    end
  endtask

  task automatic test_stall();
    w0 = wr_cnt;
    sb.push_back('{32'h0, 1'b0, 6});
    run_req(1'b1, 2'd2, 1'b0, 32'h1C, 32'hCAFEF00D, 4, r, er, lat, to, un, rh, ra);
    e = sb.pop_front();
    total++;
    if (to || er !== e.err || lat !== e.lat) begin
      bad++;
      $display("FAIL stall_rsp got err=%b lat=%0d timeout=%b want err=%b lat=%0d", er, lat, to, e.err, e.lat);
    end
    total++;
    if (un !== 0) begin bad++; $display("FAIL stall_stable got changes=%0d want 0", un); end
    total++;
    if (wr_cnt - w0 !== 1 || sram[7] !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL stall_write got n=%0d word7=%h want n=1 word7=cafef00d", wr_cnt - w0, sram[7]);
    end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    sb.push_back('{32'h0, 1'b1, 1});
    sb.push_back('{32'h0, 1'b1, 1});
`else
    sb.push_back('{32'h1122A544, 1'b0, 3});
    sb.push_back('{32'hFFFFAABB, 1'b0, 3});
`endif
    run_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, r, er, lat, to, un, rh, ra);
    e = sb.pop_front();
    total++;
    if (to || r !== e.rdata || er !== e.err || lat !== e.lat) begin
      bad++;
      $display("FAIL misalign_word got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d", r, er, lat, e.rdata, e.err, e.lat);
    end
    run_req(1'b0, 2'd1, 1'b0, 32'h15, 32'h0, 0, r, er, lat, to, un, rh, ra);
    e = sb.pop_front();
    total++;
    if (to || r !== e.rdata || er !== e.err || lat !== e.lat) begin
      bad++;
      $display("FAIL misalign_half got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d", r, er, lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    tab[0] = '{0, 2'd2, 0, 32'h1C, 0, 32'hCAFEF00D, 0, 0, 3};
    tab[1] = '{0, 2'd0, 1, 32'h1F, 0, 32'h000000CA, 0, 0, 3};
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{tab[i].exp_rdata, 1'b0, 3});
      run_req(1'b0, tab[i].size, tab[i].uns, tab[i].addr, 32'h0, 0, r, er, lat, to, un, rh, ra);
      e = sb.pop_front();
      total++;
      if (to || r !== e.rdata || er !== e.err || lat !== e.lat) begin
        bad++;
        $display("FAIL b2b%0d got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d", i, r, er, lat, e.rdata, e.err, e.lat);
      end
      total++;
      if (rh !== 1'b0 || ra !== 1'b1) begin
        bad++;
        $display("FAIL b2b%0d_ready got at_handshake=%b after=%b want 0 then 1", i, rh, ra);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    w0 = wr_cnt;
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h14; req_wdata = 32'h0;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge HCLK); #1; k++; end
    @(posedge HCLK); #1;
    req_valid = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    mem_ready = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata} !== {4'b1000, 96'h0}) begin
      bad++;
      $display("FAIL midreset_values got rdy=%b v=%b err=%b we=%b rd=%h ma=%h wd=%h want rdy=1 rest 0",
               req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata);
    end
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    total++;
    if (wr_cnt != w0 || sram[5] !== 32'h1234AABB || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_write got writes=%0d word5=%h we=%b want writes=0 word5=1234aabb we=0",
               wr_cnt - w0, sram[5], mem_we);
    end
  endtask

  task automatic test_ready_after_reset();
    sb.push_back('{32'h1234AABB, 1'b0, 6});
    run_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 3, r, er, lat, to, un, rh, ra);
    e = sb.pop_front();
    total++;
    if (to || r !== e.rdata || er !== e.err || lat !== e.lat) begin
      bad++;
      $display("FAIL ready_low_load got rdata=%h err=%b lat=%0d timeout=%b want rdata=%h err=%b lat=%0d",
               r, er, lat, to, e.rdata, e.err, e.lat);
    end
  endtask

  initial begin
    preload(13'd4, 32'h11223344);
    preload(13'd5, 32'h8899AABB);
    preload(13'd6, 32'h7F80FF01);
    preload(13'd7, 32'h00000000);
    test_reset();
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    test_load();
    test_store();
    test_error();
    test_stall();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_ready_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
